// File: rtl/vanilla_instr_encoder.sv
// vanilla_instr_encoder: turns one field-level operation request per handshake
// into RV32 instruction words. Illegal requests are consumed and reported
// with a one-cycle err_o pulse. LI expands to LUI (+ ADDI when needed).
module vanilla_instr_encoder #(
    parameter bit enable_fp_p = 1'b1
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        v_i,
    output logic        ready_o,
    input  logic [3:0]  op_i,
    input  logic [4:0]  rd_i,
    input  logic [4:0]  rs1_i,
    input  logic [4:0]  rs2_i,
    input  logic [31:0] imm_i,
    output logic        v_o,
    output logic [31:0] instr_o,
    input  logic        yumi_i,
    output logic        err_o
);

    typedef enum logic [0:0] {IDLE, EMIT_LO} state_e;

    typedef enum logic [3:0] {
        OP_ADDI  = 4'd0,
        OP_ADD   = 4'd1,
        OP_LW    = 4'd2,
        OP_SW    = 4'd3,
        OP_BEQ   = 4'd4,
        OP_JAL   = 4'd5,
        OP_LUI   = 4'd6,
        OP_LI    = 4'd7,
        OP_FLW   = 4'd8,
        OP_FSW   = 4'd9,
        OP_AMOSW = 4'd10,
        OP_FENCE = 4'd11,
        OP_MRET  = 4'd12
    } op_e;

    state_e      state_q;
    logic        v_q;
    logic        err_q;
    logic [31:0] instr_q;
    logic [31:0] lo_q;

    logic        accept;
    logic        legal_d;
    logic        has_lo_d;
    logic [31:0] word_d;
    logic [31:0] lo_d;
    logic        fits12;
    logic        fits13;
    logic        fits21;
    logic [19:0] li_upper;

    function automatic logic [31:0] i_type(input logic [11:0] imm, input logic [4:0] rs1,
                                           input logic [2:0] f3, input logic [4:0] rd,
                                           input logic [6:0] opc);
        return {imm, rs1, f3, rd, opc};
    endfunction

    function automatic logic [31:0] s_type(input logic [11:0] imm, input logic [4:0] rs2,
                                           input logic [4:0] rs1, input logic [2:0] f3,
                                           input logic [6:0] opc);
        return {imm[11:5], rs2, rs1, f3, imm[4:0], opc};
    endfunction

    assign ready_o = (state_q == IDLE) && (!v_q || yumi_i);
    assign accept  = v_i && ready_o;
    assign v_o     = v_q;
    assign instr_o = instr_q;
    assign err_o   = err_q;

    // Signed range checks: upper bits must be a pure sign extension.
    assign fits12 = (&imm_i[31:11]) || !(|imm_i[31:11]);
    assign fits13 = (&imm_i[31:12]) || !(|imm_i[31:12]);
    assign fits21 = (&imm_i[31:20]) || !(|imm_i[31:20]);

    // (imm + 0x800) >> 12: the +0x800 carries into bit 12 exactly when imm[11] is set.
    assign li_upper = imm_i[31:12] + {19'd0, imm_i[11]};

    // Decode the request into legality, first word and optional trailing ADDI.
    always_comb begin
        legal_d  = 1'b0;
        has_lo_d = 1'b0;
        word_d   = '0;
        lo_d     = '0;
        case (op_i)
            OP_ADDI: begin
                legal_d = fits12;
                word_d  = i_type(imm_i[11:0], rs1_i, 3'd0, rd_i, 7'h13);
            end
            OP_ADD: begin
                legal_d = 1'b1;
                word_d  = {7'd0, rs2_i, rs1_i, 3'd0, rd_i, 7'h33};
            end
            OP_LW: begin
                legal_d = fits12;
                word_d  = i_type(imm_i[11:0], rs1_i, 3'd2, rd_i, 7'h03);
            end
            OP_SW: begin
                legal_d = fits12;
                word_d  = s_type(imm_i[11:0], rs2_i, rs1_i, 3'd2, 7'h23);
            end
            OP_BEQ: begin
                legal_d = fits13 && !imm_i[0];
                word_d  = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, 3'd0,
                           imm_i[4:1], imm_i[11], 7'h63};
            end
            OP_JAL: begin
                legal_d = fits21 && !imm_i[0];
                word_d  = {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12], rd_i, 7'h6F};
            end
            OP_LUI: begin
                legal_d = !(|imm_i[31:20]);
                word_d  = {imm_i[19:0], rd_i, 7'h37};
            end
            OP_LI: begin
                legal_d = 1'b1;
                if (fits12) begin
                    word_d = i_type(imm_i[11:0], 5'd0, 3'd0, rd_i, 7'h13);
                end else begin
                    word_d   = {li_upper, rd_i, 7'h37};
                    has_lo_d = |imm_i[11:0];
                    lo_d     = i_type(imm_i[11:0], rd_i, 3'd0, rd_i, 7'h13);
                end
            end
            OP_FLW: begin
                legal_d = enable_fp_p && fits12;
                word_d  = i_type(imm_i[11:0], rs1_i, 3'd2, rd_i, 7'h07);
            end
            OP_FSW: begin
                legal_d = enable_fp_p && fits12;
                word_d  = s_type(imm_i[11:0], rs2_i, rs1_i, 3'd2, 7'h27);
            end
            OP_AMOSW: begin
                legal_d = 1'b1;
                word_d  = {5'h01, 2'b00, rs2_i, rs1_i, 3'd2, rd_i, 7'h2F};
            end
            OP_FENCE: begin
                legal_d = 1'b1;
                word_d  = 32'h0FF0000F;
            end
            OP_MRET: begin
                legal_d = 1'b1;
                word_d  = 32'h30200073;
            end
            default: legal_d = 1'b0;
        endcase
    end

    // Output register, error pulse and pending-ADDI sequencing.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            v_q     <= 1'b0;
            err_q   <= 1'b0;
            instr_q <= '0;
            lo_q    <= '0;
        end else begin
            err_q <= accept && !legal_d;
            unique case (state_q)
                IDLE: begin
                    if (accept && legal_d) begin
                        v_q     <= 1'b1;
                        instr_q <= word_d;
                        if (has_lo_d) begin
                            lo_q    <= lo_d;
                            state_q <= EMIT_LO;
                        end
                    end else if (yumi_i) begin
                        v_q <= 1'b0;
                    end
                end
                EMIT_LO: begin
                    if (!v_q || yumi_i) begin
                        v_q     <= 1'b1;
                        instr_q <= lo_q;
                        state_q <= IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vanilla_instr_encoder.sv
// Bench for vanilla_instr_encoder: cycle model with an output-word queue,
// checked every cycle, plus directed literal expectations.
module tb_vanilla_instr_encoder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_i, v_i, yumi_en, yumi_i, ready_o, v_o, err_o;
    logic [3:0]  op_i;
    logic [4:0]  rd_i, rs1_i, rs2_i;
    logic [31:0] imm_i, instr_o;
    logic        v2_i, ready2_o, v2_o, err2_o, yumi2_i;
    logic [31:0] instr2_o;

    assign yumi_i  = yumi_en & v_o;
    assign yumi2_i = v2_o;

    vanilla_instr_encoder #(.enable_fp_p(1'b1)) dut (
        .clk_i(clk), .reset_i(reset_i), .v_i(v_i), .ready_o(ready_o), .op_i(op_i),
        .rd_i(rd_i), .rs1_i(rs1_i), .rs2_i(rs2_i), .imm_i(imm_i), .v_o(v_o),
        .instr_o(instr_o), .yumi_i(yumi_i), .err_o(err_o)
    );

    vanilla_instr_encoder #(.enable_fp_p(1'b0)) dut_nofp (
        .clk_i(clk), .reset_i(reset_i), .v_i(v2_i), .ready_o(ready2_o), .op_i(op_i),
        .rd_i(rd_i), .rs1_i(rs1_i), .rs2_i(rs2_i), .imm_i(imm_i), .v_o(v2_o),
        .instr_o(instr2_o), .yumi_i(yumi2_i), .err_o(err2_o)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // ---------------- reference encoder (plain arithmetic) ----------------
    function automatic logic [31:0] itype(input logic [31:0] imm, input int rs1, input int f3,
                                          input int rd, input int opc);
        return ((imm & 32'hFFF) << 20) | (32'(rs1) << 15) | (32'(f3) << 12) |
               (32'(rd) << 7) | 32'(opc);
    endfunction

    function automatic logic [31:0] stype(input logic [31:0] imm, input int rs2, input int rs1,
                                          input int f3, input int opc);
        return (((imm >> 5) & 32'h7F) << 25) | (32'(rs2) << 20) | (32'(rs1) << 15) |
               (32'(f3) << 12) | ((imm & 32'h1F) << 7) | 32'(opc);
    endfunction

    function automatic void enc(input int op, input int rd, input int rs1, input int rs2,
                                input logic [31:0] imm, input bit fp, output bit legal,
                                output int n, output logic [31:0] w0, output logic [31:0] w1);
        int s;
        logic [31:0] up;
        s = $signed(imm);
        legal = 1'b1; n = 1; w0 = '0; w1 = '0;
        case (op)
            0: begin legal = (s >= -2048 && s <= 2047); w0 = itype(imm, rs1, 0, rd, 'h13); end
            1: w0 = (32'(rs2) << 20) | (32'(rs1) << 15) | (32'(rd) << 7) | 32'h33;
            2: begin legal = (s >= -2048 && s <= 2047); w0 = itype(imm, rs1, 2, rd, 'h03); end
            3: begin legal = (s >= -2048 && s <= 2047); w0 = stype(imm, rs2, rs1, 2, 'h23); end
            4: begin
                legal = (s >= -4096 && s <= 4094 && (s % 2) == 0);
                w0 = (((imm >> 12) & 1) << 31) | (((imm >> 5) & 32'h3F) << 25) |
                     (32'(rs2) << 20) | (32'(rs1) << 15) | (((imm >> 1) & 32'hF) << 8) |
                     (((imm >> 11) & 1) << 7) | 32'h63;
            end
            5: begin
                legal = (s >= -1048576 && s <= 1048574 && (s % 2) == 0);
                w0 = (((imm >> 20) & 1) << 31) | (((imm >> 1) & 32'h3FF) << 21) |
                     (((imm >> 11) & 1) << 20) | (((imm >> 12) & 32'hFF) << 12) |
                     (32'(rd) << 7) | 32'h6F;
            end
            6: begin legal = ((imm >> 20) == 0); w0 = (imm << 12) | (32'(rd) << 7) | 32'h37; end
            7: begin
                if (s >= -2048 && s <= 2047) w0 = itype(imm, 0, 0, rd, 'h13);
                else begin
                    up = (imm + 32'h800) >> 12;
                    w0 = (up << 12) | (32'(rd) << 7) | 32'h37;
                    if ((imm & 32'hFFF) != 0) begin n = 2; w1 = itype(imm, rd, 0, rd, 'h13); end
                end
            end
            8: begin legal = fp && (s >= -2048 && s <= 2047); w0 = itype(imm, rs1, 2, rd, 'h07); end
            9: begin legal = fp && (s >= -2048 && s <= 2047); w0 = stype(imm, rs2, rs1, 2, 'h27); end
            10: w0 = (32'h01 << 27) | (32'(rs2) << 20) | (32'(rs1) << 15) | (32'd2 << 12) |
                     (32'(rd) << 7) | 32'h2F;
            11: w0 = 32'h0FF0000F;
            12: w0 = 32'h30200073;
            default: legal = 1'b0;
        endcase
    endfunction

    // ---------------- cycle model + compare process ----------------
    bit          m_on = 1'b0, m_v = 1'b0, m_err = 1'b0;
    logic [31:0] m_word = '0;
    logic [31:0] m_pend[$];
    logic [31:0] ret_w[$];
    int          ret_c[$];
    int          err_pulses = 0;
    int          cyc = 0;
    bit          exp_ready, acc, lg;
    int          mn;
    logic [31:0] mw0, mw1;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        exp_ready = (m_pend.size() == 0) && (!m_v || yumi_i);
        if (m_on) begin
            chk("v_o", v_o, m_v);
            if (m_v) chk("instr_o", instr_o, m_word);
            chk("err_o", err_o, m_err);
            chk("ready_o", ready_o, exp_ready);
            if (v_o && yumi_i) begin ret_w.push_back(instr_o); ret_c.push_back(cyc); end
            if (err_o) err_pulses++;
        end
        if (reset_i) begin
            m_on = 1'b1; m_v = 1'b0; m_err = 1'b0; m_word = '0; m_pend.delete();
        end else if (m_on) begin
            acc = v_i && exp_ready;
            enc(int'(op_i), int'(rd_i), int'(rs1_i), int'(rs2_i), imm_i, 1'b1, lg, mn, mw0, mw1);
            m_err = acc && !lg;
            if (m_v && yumi_i) m_v = 1'b0;
            if (m_pend.size() != 0) begin
                if (!m_v) begin m_v = 1'b1; m_word = m_pend.pop_front(); end
            end else if (acc && lg) begin
                m_v = 1'b1; m_word = mw0;
                if (mn == 2) m_pend.push_back(mw1);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic send(input int op, input int rd, input int rs1, input int rs2,
                        input logic [31:0] imm);
        int k;
        op_i = op[3:0]; rd_i = rd[4:0]; rs1_i = rs1[4:0]; rs2_i = rs2[4:0]; imm_i = imm;
        v_i = 1'b1;
        k = 0;
        @(negedge clk);
        while (!ready_o && k < 50) begin @(negedge clk); k++; end
        if (!ready_o) begin
            checks++; errors++;
            $display("FAIL send_timeout: ready_o stayed %b, required 1", ready_o);
        end
        @(posedge clk); #1;
        v_i = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk_ret(input string name, input int idx, input logic [31:0] exp);
        if (idx < ret_w.size()) chk(name, ret_w[idx], exp);
        else begin
            checks++; errors++;
            $display("FAIL %s: no word retired, required %h", name, exp);
        end
    endtask

    task automatic chk_err(input string name, input int e0, input int b0);
        chk({name, "_errpulse"}, err_pulses - e0, 1);
        chk({name, "_noword"}, ret_w.size() - b0, 0);
    endtask

    int b, e;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_i = 1'b1; v_i = 1'b0; v2_i = 1'b0; yumi_en = 1'b1;
        op_i = '0; rd_i = '0; rs1_i = '0; rs2_i = '0; imm_i = '0;
        idle(3);
        reset_i = 1'b0;
        @(negedge clk);
        chk("rst_v_o", v_o, 0); chk("rst_instr_o", instr_o, 0);
        chk("rst_err_o", err_o, 0); chk("rst_ready_o", ready_o, 1);
        @(posedge clk); #1;

        // ADDI then ADD back to back
        b = ret_w.size();
        send(0, 1, 0, 0, 32'd5);
        send(1, 3, 1, 2, 32'd0);
        idle(3);
        chk_ret("addi", b, 32'h00500093);
        chk_ret("add", b + 1, 32'h002081B3);
        if (ret_w.size() >= b + 2) chk("addi_add_gap", ret_c[b+1] - ret_c[b], 1);

        // LI pair, yumi high
        b = ret_w.size();
        send(7, 5, 0, 0, 32'h12345678);
        idle(3);
        chk_ret("li_lui", b, 32'h123452B7);
        chk_ret("li_addi", b + 1, 32'h67828293);
        if (ret_w.size() >= b + 2) chk("li_gap", ret_c[b+1] - ret_c[b], 1);

        // LI pair with consumer stalled for 3 cycles
        b = ret_w.size();
        yumi_en = 1'b0;
        send(7, 5, 0, 0, 32'h12345678);
        repeat (3) begin
            @(negedge clk);
            chk("stall_v", v_o, 1); chk("stall_word", instr_o, 32'h123452B7);
            chk("stall_ready", ready_o, 0);
        end
        @(posedge clk); #1;
        yumi_en = 1'b1;
        @(negedge clk);
        chk("lui_retire_ready", ready_o, 0);
        @(negedge clk);
        chk("lo_word", instr_o, 32'h67828293); chk("lo_ready", ready_o, 1);
        idle(2);
        chk_ret("stall_lui", b, 32'h123452B7);
        chk_ret("stall_addi", b + 1, 32'h67828293);

        // LI corner cases
        b = ret_w.size();
        send(7, 5, 0, 0, 32'hFFFFF800);
        send(7, 6, 0, 0, 32'h00000800);
        send(7, 7, 0, 0, 32'h00003000);
        idle(4);
        chk("li_corner_count", ret_w.size() - b, 4);
        chk_ret("li_neg2048", b, 32'h80000293);
        chk_ret("li_800_lui", b + 1, 32'h00001337);
        chk_ret("li_800_addi", b + 2, 32'h80030313);
        chk_ret("li_3000", b + 3, 32'h000033B7);

        // System constants
        b = ret_w.size();
        send(12, 0, 0, 0, 32'd0);
        send(11, 0, 0, 0, 32'd0);
        idle(3);
        chk_ret("mret", b, 32'h30200073);
        chk_ret("fence", b + 1, 32'h0FF0000F);

        // Illegal requests
        b = ret_w.size(); e = err_pulses;
        send(4, 0, 1, 2, 32'd3); idle(2); chk_err("beq_odd", e, b);
        b = ret_w.size(); e = err_pulses;
        send(3, 0, 1, 2, 32'd2048); idle(2); chk_err("sw_2048", e, b);
        b = ret_w.size(); e = err_pulses;
        send(14, 1, 1, 1, 32'd0); idle(2); chk_err("op14", e, b);

        // Boundary sweep (model checks every word, counts checked here)
        b = ret_w.size(); e = err_pulses;
        send(0, 1, 2, 0, 32'd2047);
        send(0, 1, 2, 0, 32'hFFFFF7FF);
        send(4, 0, 3, 4, 32'd4094);
        send(4, 0, 3, 4, 32'hFFFFF000);
        send(4, 0, 3, 4, 32'd4096);
        send(5, 1, 0, 0, 32'h000FFFFE);
        send(5, 1, 0, 0, 32'h00100000);
        send(5, 1, 0, 0, 32'hFFF00000);
        send(6, 9, 0, 0, 32'h000ABCDE);
        send(6, 9, 0, 0, 32'h00100000);
        send(2, 4, 2, 0, 32'hFFFFFFFC);
        send(3, 0, 8, 7, 32'hFFFFF800);
        send(8, 2, 3, 0, 32'd8);
        send(9, 0, 3, 4, 32'd12);
        send(10, 3, 4, 5, 32'd0);
        send(13, 0, 0, 0, 32'd0);
        send(15, 0, 0, 0, 32'd0);
        idle(3);
        chk("sweep_words", ret_w.size() - b, 11);
        chk("sweep_errs", err_pulses - e, 6);
        chk_ret("lw_neg4", b + 6, 32'hFFC12203);
        chk_ret("flw", b + 8, 32'h0081A107);

        // FP disabled instance
        op_i = 4'd8; rd_i = 5'd2; rs1_i = 5'd3; rs2_i = 5'd0; imm_i = 32'd8;
        v2_i = 1'b1;
        @(negedge clk); chk("nofp_ready", ready2_o, 1);
        @(posedge clk); #1; v2_i = 1'b0;
        @(negedge clk); chk("nofp_err", err2_o, 1); chk("nofp_v", v2_o, 0);
        @(negedge clk); chk("nofp_err_clr", err2_o, 0);
        @(posedge clk); #1;
        op_i = 4'd2; rd_i = 5'd4; rs1_i = 5'd2; imm_i = 32'hFFFFFFFC;
        v2_i = 1'b1;
        @(posedge clk); #1; v2_i = 1'b0;
        @(negedge clk); chk("nofp_lw_v", v2_o, 1); chk("nofp_lw", instr2_o, 32'hFFC12203);
        idle(2);

        // Reset while a pending ADDI sits behind a stalled LUI
        yumi_en = 1'b0;
        send(7, 5, 0, 0, 32'h12345678);
        @(negedge clk); chk("pre_rst_v", v_o, 1);
        @(posedge clk); #1; reset_i = 1'b1;
        @(posedge clk); #1; reset_i = 1'b0;
        b = ret_w.size();
        yumi_en = 1'b1;
        @(negedge clk);
        chk("post_rst_v", v_o, 0); chk("post_rst_ready", ready_o, 1); chk("post_rst_err", err_o, 0);
        idle(5);
        chk("post_rst_noword", ret_w.size() - b, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
